// File: rtl/seq_gen_prog.sv
// seq_gen_prog: programmable sequence generator.
// Plays words from a DEPTH x DATA_W table over a valid/ready stream, in loop
// or one-shot mode. The table is written through a simple write port while the
// generator is idle. Reset loads a fixed default pattern into the table.
//
// Ports:
//   clk      - clock, rising edge
//   reset_n  - synchronous active-low reset
//   enable   - run gate; low pauses the sequence (valid drops, position held)
//   start    - request to begin a sequence (accepted only in IDLE)
//   mode     - 0 = loop, 1 = one-shot (sampled with start)
//   seq_len  - number of entries to play; 0 or > DEPTH means DEPTH
//   wr_en    - table write strobe (IDLE only, not on the start cycle)
//   wr_addr  - table write address
//   wr_data  - table write data
//   data     - current sequence word (0 while idle)
//   valid    - data is valid
//   ready    - consumer accepts data
//   busy     - high while running
//   done     - one-cycle pulse when a one-shot sequence completes
module seq_gen_prog #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              start,
  input  logic              mode,
  input  logic [ADDR_W:0]   seq_len,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  input  logic              ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_FULL = ADDR_W'(DEPTH - 1);

  state_t              state;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [ADDR_W-1:0]   idx;
  logic [ADDR_W-1:0]   last_idx;   // effective length minus one
  logic                one_shot;
  logic [ADDR_W:0]     seq_m1;
  logic [ADDR_W-1:0]   last_sel;
  logic                xfer;

  function automatic logic [7:0] init_word(input int unsigned i);
    case (i)
      0:       init_word = 8'hAF;
      1:       init_word = 8'hBC;
      2:       init_word = 8'hE2;
      3:       init_word = 8'h78;
      4:       init_word = 8'hFF;
      5:       init_word = 8'hE2;
      6:       init_word = 8'h0B;
      7:       init_word = 8'h8D;
      default: init_word = 8'h00;
    endcase
  endfunction

  // Length is stored as its last index so the wrap test is a plain compare.
  always_comb begin
    seq_m1 = seq_len - (ADDR_W+1)'(1);
    if (seq_len == '0 || seq_len > DEPTH_L) last_sel = LAST_FULL;
    else                                   last_sel = seq_m1[ADDR_W-1:0];
  end

  assign xfer = valid & ready;

  // Table: reset pattern, writes only while idle and not starting.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++)
        mem[ADDR_W'(i)] <= DATA_W'(init_word(i));
    end else if (state == IDLE && wr_en && !start) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      idx      <= '0;
      last_idx <= '0;
      one_shot <= 1'b0;
      data     <= '0;
      valid    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          data  <= '0;
          valid <= 1'b0;
          busy  <= 1'b0;
          if (start) begin
            state    <= RUN;
            idx      <= '0;
            last_idx <= last_sel;
            one_shot <= mode;
            data     <= mem[0];
            busy     <= 1'b1;
            valid    <= enable;
          end
        end
        RUN: begin
          if (xfer && idx == last_idx) begin
            if (one_shot) begin
              state <= IDLE;
              idx   <= '0;
              data  <= '0;
              valid <= 1'b0;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              idx   <= '0;
              data  <= mem[0];
              valid <= enable;
            end
          end else if (xfer) begin
            // Next word loads on the accepting edge: no bubble between words.
            idx   <= idx + ADDR_W'(1);
            data  <= mem[idx + ADDR_W'(1)];
            valid <= enable;
          end else begin
            // No transfer: position and word held; valid follows enable.
            valid <= enable;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_gen_prog.sv
// tb_seq_gen_prog: self-checking bench for seq_gen_prog with a behavioural
// model (table array + play position) and directed plus random stimulus.
module tb_seq_gen_prog;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

  logic              clk = 1'b0;
  logic              reset_n, enable, start, mode, wr_en, ready;
  logic [ADDR_W:0]   seq_len;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] data;
  logic              valid, busy, done;

  seq_gen_prog #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .start(start), .mode(mode),
    .seq_len(seq_len), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .data(data), .valid(valid), .ready(ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  logic [7:0] dflt [8] = '{8'hAF, 8'hBC, 8'hE2, 8'h78, 8'hFF, 8'hE2, 8'h0B, 8'h8D};

  // Reference model state
  logic [DATA_W-1:0] m_tab [DEPTH];
  bit                m_run, m_valid, m_done, m_oneshot;
  int                m_pos, m_len;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one edge using the inputs currently applied.
  task automatic model_step();
    m_done = 0;
    if (!reset_n) begin
      m_run = 0; m_valid = 0; m_pos = 0;
      for (int i = 0; i < DEPTH; i++) m_tab[i] = (i < 8) ? dflt[i] : '0;
    end else if (!m_run) begin
      if (start) begin
        m_run = 1; m_pos = 0; m_oneshot = mode; m_valid = enable;
        m_len = (seq_len == 0 || seq_len > DEPTH) ? DEPTH : int'(seq_len);
      end else if (wr_en) begin
        m_tab[wr_addr] = wr_data;
      end
    end else begin
      if (m_valid && ready) begin
        if (m_pos == m_len - 1 && m_oneshot) begin
          m_run = 0; m_valid = 0; m_done = 1; m_pos = 0;
        end else begin
          m_pos = (m_pos + 1) % m_len;
          m_valid = enable;
        end
      end else begin
        m_valid = enable;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("valid", 32'(valid), 32'(m_valid));
    check("busy",  32'(busy),  32'(m_run));
    check("done",  32'(done),  32'(m_done));
    check("data",  32'(data),  m_run ? 32'(m_tab[m_pos]) : 32'h0);
  endtask

  task automatic pulse_start(input logic md, input logic [ADDR_W:0] len);
    start = 1; mode = md; seq_len = len;
    tick();
    start = 0;
  endtask

  initial begin
    reset_n = 0; enable = 1; start = 0; mode = 0; seq_len = '0;
    wr_en = 0; wr_addr = '0; wr_data = '0; ready = 1;
    m_run = 0; m_valid = 0; m_done = 0; m_pos = 0; m_len = DEPTH; m_oneshot = 0;
    @(negedge clk);
    tick(); tick();
    check("reset_data", 32'(data), 32'h0);
    reset_n = 1;
    tick();

    // Loop over the default table at full rate
    pulse_start(1'b0, '0);
    for (int i = 0; i < 100; i++) begin
      check("loop_seq", 32'(data), 32'(dflt[i % 8]));
      tick();
    end
    reset_n = 0; tick(); reset_n = 1; tick();

    // One-shot of three words, then a replay
    pulse_start(1'b1, 4'd3);
    check("oneshot_w0", 32'(data), 32'hAF);
    tick(); tick();
    check("oneshot_w2", 32'(data), 32'hE2);
    tick();
    check("oneshot_done", 32'(done), 32'h1);
    tick();
    check("done_one_cycle", 32'(done), 32'h0);
    pulse_start(1'b1, 4'd3);
    check("replay_w0", 32'(data), 32'hAF);
    for (int i = 0; i < 4; i++) tick();

    // Backpressure while BC is presented
    pulse_start(1'b0, 4'd8);
    tick();
    ready = 0;
    for (int i = 0; i < 3; i++) tick();
    check("stall_hold", 32'(data), 32'hBC);
    ready = 1; tick();
    check("after_stall", 32'(data), 32'hE2);
    // Pause with enable low while E2 is held
    ready = 0; enable = 0; tick(); tick();
    check("paused_valid", 32'(valid), 32'h0);
    enable = 1; tick();
    check("resumed_data", 32'(data), 32'hE2);
    ready = 1; tick();
    check("resumed_next", 32'(data), 32'h78);
    reset_n = 0; tick(); reset_n = 1;

    // Program two entries, loop of length two, write attempt during run
    wr_en = 1; wr_addr = 3'd0; wr_data = 8'h55; tick();
    wr_addr = 3'd1; wr_data = 8'h66; tick();
    wr_en = 0;
    pulse_start(1'b0, 4'd2);
    for (int i = 0; i < 4; i++) begin
      check("prog_seq", 32'(data), (i % 2 == 0) ? 32'h55 : 32'h66);
      wr_en = (i == 1); wr_addr = 3'd0; wr_data = 8'h11;
      tick();
    end
    wr_en = 0;
    check("run_write_ignored", 32'(data), 32'h55);

    // Reset mid-run restores the default table
    reset_n = 0; tick();
    check("mid_reset_busy", 32'(busy), 32'h0);
    reset_n = 1; tick();
    pulse_start(1'b0, '0);
    check("post_reset_first", 32'(data), 32'hAF);

    // Randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      reset_n = ($urandom % 100) != 0;
      start   = ($urandom % 10) == 0;
      mode    = $urandom % 2;
      seq_len = ($urandom_range(0, 15));
      enable  = ($urandom % 5) != 0;
      ready   = ($urandom % 3) != 0;
      wr_en   = ($urandom % 3) == 0;
      wr_addr = ($urandom_range(0, DEPTH - 1));
      wr_data = ($urandom % 256);
      tick();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
